// File: rtl/clk_period_meter.sv
// Measures sig_in period in clk cycles; CLK_PERIOD_METER_DUTY_MEAS_EN adds high_time.
// Latency: SYNC_STAGES+1 cycles from a sig_in edge to detection, result one cycle after the closing edge.
// Backpressure: result is held in DONE (period/ovf stable) until res_valid & res_ready.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] period,
    output logic             ovf
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_s;
    logic                   rise;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             ovf_q, ovf_d;

    // Both edges traverse the same chain, so edge-to-edge distance is preserved exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~prev_q;

`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        ovf_d    = ovf_q;
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
        hcnt_d   = hcnt_q;
        high_d   = high_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_ONE;
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
                    hcnt_d  = CNT_ONE;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = ST_DONE;
                    period_d = '0;
                    ovf_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    state_d  = ST_DONE;
                    period_d = cnt_q;
                    ovf_d    = 1'b0;
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
                    high_d   = hcnt_q;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = ST_DONE;
                    period_d = CNT_MAX;
                    ovf_d    = 1'b1;
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
                    high_d   = hcnt_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
                    // sync_s is next cycle's prev, so hcnt_q counts prev=1 cycles up to and including now.
                    if (sync_s && (hcnt_q != CNT_MAX)) begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
`endif
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_time = high_q;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign period    = period_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed + randomized bench for clk_period_meter (CNT_W=8); sig_in is generated clk-aligned
// so the expected period is simply high+low cycles, clamped to 255 with ovf.
module tb_clk_period_meter;

    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sig_in;
    logic          start;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] period;
    logic          ovf;
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
    logic [CW-1:0] high_time;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int   hi_len    = 6;
    int   lo_len    = 6;
    bit   gen_en    = 1'b0;
    logic const_val = 1'b0;
    int   rise_cnt  = 0;

    clk_period_meter #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .start     (start),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .period    (period),
        .ovf       (ovf)
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
        ,
        .high_time (high_time)
`endif
    );

    always #5 clk = ~clk;

    // Waveform source: high for hi_len cycles, low for lo_len cycles, or a constant level.
    initial begin
        forever begin
            if (gen_en) begin
                sig_in = 1'b1;
                rise_cnt++;
                repeat (hi_len) @(negedge clk);
                sig_in = 1'b0;
                repeat (lo_len) @(negedge clk);
            end else begin
                sig_in = const_val;
                @(negedge clk);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_wave(input int hi, input int lo);
        hi_len = hi;
        lo_len = lo;
        gen_en = 1'b1;
        repeat (360 + 2 * (hi + lo)) @(negedge clk);
    endtask

    task automatic set_const(input logic v);
        gen_en    = 1'b0;
        const_val = v;
        repeat (360) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issue start a few cycles before a rising edge so long periods still see an edge inside ARM.
    task automatic start_aligned(input string tag, input int per);
        int r0;
        r0 = rise_cnt;
        for (int i = 0; i < 2 * per + 20 && rise_cnt == r0; i++) @(negedge clk);
        repeat ((per > 12) ? per - 8 : 2) @(negedge clk);
        pulse_start();
        chk({tag, "_busy_after_start"}, busy, 1);
    endtask

    task automatic wait_valid(output int w);
        w = 0;
        while (!res_valid && w < 700) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic collect(input string tag, input int exp_per, input bit exp_ovf,
                           input int exp_hi, input bit chk_hi, output int w);
        wait_valid(w);
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_period"}, period, exp_per);
        chk({tag, "_ovf"}, ovf, exp_ovf);
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
        if (chk_hi) chk({tag, "_high_time"}, high_time, exp_hi);
`endif
        res_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_released"}, {busy, res_valid}, 0);
        res_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int hi, lo, per;
        logic [CW-1:0] p_hold;

        rst_n     = 1'b0;
        start     = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_period", period, 0);
        chk("rst_ovf", ovf, 0);
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
        chk("rst_high_time", high_time, 0);
`endif
        rst_n = 1'b1;

        // Period 12, consumer always ready
        set_wave(6, 6);
        res_ready = 1'b1;
        start_aligned("p12", 12);
        collect("p12", 12, 1'b0, 6, 1'b1, w);

        // High 3 / low 7
        set_wave(3, 7);
        start_aligned("p10", 10);
        collect("p10", 10, 1'b0, 3, 1'b1, w);

        // Constant low and constant high both end in ARM timeout
        set_const(1'b0);
        pulse_start();
        collect("const0", 0, 1'b1, 0, 1'b0, w);
        chk("const0_timeout_len", (w >= 255 && w <= 257), 1);
        set_const(1'b1);
        pulse_start();
        collect("const1", 0, 1'b1, 0, 1'b0, w);
        chk("const1_timeout_len", (w >= 255 && w <= 257), 1);

        // Period 300 saturates at 255 without wrapping
        set_wave(150, 150);
        start_aligned("p300", 300);
        collect("p300", CMAX, 1'b1, 0, 1'b0, w);

        // Randomized in-range periods
        for (int k = 0; k < 6; k++) begin
            hi  = $urandom_range(40, 2);
            lo  = $urandom_range(40, 8);
            per = hi + lo;
            set_wave(hi, lo);
            start_aligned($sformatf("rnd%0d", k), per);
            collect($sformatf("rnd%0d_p%0d", k, per), per, 1'b0, hi, 1'b1, w);
        end

        // Randomized over-range periods
        for (int k = 0; k < 2; k++) begin
            hi  = $urandom_range(170, 130);
            lo  = $urandom_range(170, 130);
            per = hi + lo;
            set_wave(hi, lo);
            start_aligned($sformatf("ovr%0d", k), per);
            collect($sformatf("ovr%0d_p%0d", k, per), CMAX, 1'b1, 0, 1'b0, w);
        end

        // Result held under backpressure; start in DONE is ignored
        set_wave(5, 9);
        start_aligned("hold", 14);
        wait_valid(w);
        chk("hold_valid", res_valid, 1);
        p_hold = 8'd14;
        for (int c = 0; c < 20; c++) begin
            start = (c == 5);
            @(negedge clk);
            chk($sformatf("hold_valid_c%0d", c), res_valid, 1);
            chk($sformatf("hold_period_c%0d", c), period, p_hold);
        end
        start     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", {busy, res_valid}, 0);
        start     = 1'b0;
        res_ready = 1'b0;
        w = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy || res_valid) w++;
        end
        chk("hold_start_ignored", w, 0);

        // Reset mid-measurement clears outputs at once; next run is clean
        set_wave(6, 6);
        start_aligned("rstm", 12);
        repeat (10) @(negedge clk);
        chk("rstm_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_busy", busy, 0);
        chk("rstm_valid", res_valid, 0);
        chk("rstm_period", period, 0);
        chk("rstm_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rstm_no_result", {busy, res_valid}, 0);
        start_aligned("after_rst", 12);
        collect("after_rst", 12, 1'b0, 6, 1'b1, w);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
